fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Producer (write side) of the instruction queue: owns the PC and issues one 32-bit read at a time to the I-cache.
//  - Packs each returned instruction with its PC into a 65-bit queue entry.
//  - Pushes the entry into the queue. Honours queue-full backpressure.
//  - On a branch-mispredict redirect, restarts fetch at the new PC.
//  Sits between the I-cache port and instruction queue input.
// PARAMETERS
//  RESET_PC    32'h1eceb000  first fetch address after reset
//  ENTRY_W     65            queue entry width {valid, pc[31:0], inst[31:0]}
// PORTS
//  clk             in   1   clock
//  rst             in   1   synchronous active-high reset
//  redirect_valid  in   1   mispredict/jump redirect, one-cycle pulse
//  redirect_pc     in   32  new fetch PC; bits [1:0] ignored (forced 0)
//  imem_addr       out  32  I-cache read address (= pc)
//  imem_rmask      out  4   4'hF for exactly one cycle per request, else 0
//  imem_rdata      in   32  read data, valid when imem_resp=1
//  imem_resp       in   1   response strobe, one cycle
//  iq_full         in   1   queue cannot accept a push this cycle
//  iq_push         out  1   push strobe (registered), one cycle per entry
//  iq_entry        out  65  {1'b1, pc, inst} when iq_push, else 0
// BEHAVIOUR
//  - Reset state is IDLE. While rst=1 and on the first cycle after release:
//    - pc=RESET_PC, imem_rmask=0, iq_push=0, iq_entry=0.
//  - State machine:
//    - IDLE -> REQ unconditionally.
//    - REQ: drive rmask=4'hF, addr=pc. Next state is WAIT.
//    - WAIT, imem_resp=1 and iq_full=0: register push (iq_push=1 next cycle), pc+=4, go to REQ.
//    - WAIT, imem_resp=1 and iq_full=1: capture {pc, rdata} in hold register, go to HOLD.
//    - HOLD: each cycle with iq_full=0, push the held entry, pc+=4, go to REQ.
//    - DRAIN: wait for imem_resp, discard the data, go to REQ. pc is already the redirect target.
//  - Only one outstanding I-cache request at a time. No request is issued in WAIT, HOLD or DRAIN.
//  - Latency:
//    - Request at cycle t, response at t+k: iq_push at t+k+1, next rmask pulse at t+k+1.
//    - Peak rate is one instruction per 2 cycles (k=1).
//  - Redirect has highest priority in every state. On redirect:
//    - pc <= {redirect_pc[31:2], 2'b00}. Held entry dropped. iq_push=0 the next cycle.
//    - Same-cycle imem_resp is discarded.
//    - From WAIT with no same-cycle resp: go to DRAIN (stale response must be eaten).
//    - From REQ: the just-issued request is outstanding, so go to DRAIN.
//    - From IDLE, HOLD, DRAIN-with-resp, or WAIT-with-resp: go to REQ.
//    - From DRAIN without resp: stay in DRAIN; pc is still updated.
//  - A redirect coincident with a push decision suppresses the push.
//  - pc arithmetic is mod 2^32 and wraps silently: 32'hFFFFFFFC+4 = 0.
//  - iq_full is sampled only in WAIT/HOLD. The queue's only producer is this block, so full cannot
//    become set between decision and push.
//  - rst asserted mid-request: return to IDLE. Any later imem_resp is ignored until the next REQ.
//  - The I-cache must not respond after its own reset.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//  - Adds 32-bit output ports perf_fetched (incremented on each iq_push) and perf_stall (incremented
//    each cycle in HOLD).
//  - Both counters reset to 0 and saturate at 32'hFFFFFFFF.
//  FETCH_PERF_EN undefined: ports and counters are absent. Functional behaviour is identical.
// STRUCTURE
//  - fetch_pkg holds:
//    - typedef enum logic [2:0] fetch_state_t {IDLE, REQ, WAIT, HOLD, DRAIN}.
//    - typedef struct packed iq_entry_t {valid, pc, inst}; $bits = 65.
//    - localparam IMEM_RMASK_ALL = 4'hF.
//  - One sub-module, fetch_hold_reg: one-entry holding register with load, clear and valid, used by
//    HOLD/redirect.
//  - The FSM and pc logic stay in fetch_unit.
// TESTING
//  1. Reset then k=1 responses with iq_full=0: rmask pulses at addr 1eceb000, 1eceb004, ...
//     Entries pushed in order, one every 2 cycles.
//  2. Response 0x00000013 with iq_full=1 for 3 cycles: no push for 3 cycles, then a single push
//     {1, pc, 0x13}, then the next request. No request is issued during HOLD.
//  3. redirect_valid in WAIT (pc=0x100, target 0x2002): go to DRAIN. The next resp is discarded
//     (no push). The next rmask has addr 0x2000.
//  4. redirect_valid in the same cycle as imem_resp: no push, go to REQ with the new PC next cycle.
//     Queue contents unchanged.
//  5. pc=32'hFFFFFFFC fetch: the next request addr is 0.
//     rst asserted during WAIT: outputs return to reset values, the next fetch is at RESET_PC.
//  6. With FETCH_PERF_EN: 10 pushes and 4 HOLD cycles give perf_fetched=10, perf_stall=4.
//     Reset clears both.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its instruction-queue interface.
package fetch_pkg;

    localparam int          ENTRY_W        = 65;
    localparam logic [3:0]  IMEM_RMASK_ALL = 4'hF;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

    // Fetch addresses are always word aligned; the low two bits are discarded.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// I-cache read port, instruction-queue push port and redirect input of the fetch unit.
interface fetch_if import fetch_pkg::*;;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        iq_full;
    logic        iq_push;
    iq_entry_t   iq_entry;

    modport master (
        input  redirect_valid, redirect_pc, imem_rdata, imem_resp, iq_full,
        output imem_addr, imem_rmask, iq_push, iq_entry
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_rdata, imem_resp, iq_full,
        input  imem_addr, imem_rmask, iq_push, iq_entry
    );

endinterface

// File: rtl/fetch_hold_reg.sv
// One-entry holding register for a fetched instruction that met a full queue.
module fetch_hold_reg import fetch_pkg::*; (
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  logic      clear,
    input  iq_entry_t d,
    output iq_entry_t q,
    output logic      valid
);

    iq_entry_t data;

    // NOTE: only the valid flag is reset; the payload is meaningless while valid=0, so it has no reset.
    always_ff @(posedge clk) begin
        if (rst || clear) valid <= 1'b0;
        else if (load)    valid <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (load) data <= d;
    end

    assign q = data;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one I-cache read at a time and pushes {valid, pc, inst} entries.
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_stall counters.
module fetch_unit import fetch_pkg::*; #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    fetch_if.master     bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic         push_q, push_next;
    iq_entry_t    entry_q, entry_next;
    logic         hold_load, hold_clear, hold_valid;
    iq_entry_t    hold_q;

    fetch_hold_reg u_hold (
        .clk   (clk),
        .rst   (rst),
        .load  (hold_load),
        .clear (hold_clear),
        .d     ('{valid: 1'b1, pc: pc, inst: bus.imem_rdata}),
        .q     (hold_q),
        .valid (hold_valid)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        push_next  = 1'b0;
        entry_next = '0;
        hold_load  = 1'b0;
        hold_clear = 1'b0;

        if (bus.redirect_valid) begin
            // A redirect wins everywhere; a request still in flight must be drained.
            pc_next    = align_pc(bus.redirect_pc);
            hold_clear = 1'b1;
            case (state)
                REQ:         state_next = DRAIN;
                WAIT, DRAIN: state_next = bus.imem_resp ? REQ : DRAIN;
                default:     state_next = REQ;
            endcase
        end else begin
            case (state)
                IDLE: state_next = REQ;
                REQ:  state_next = WAIT;
                WAIT: begin
                    if (bus.imem_resp) begin
                        if (!bus.iq_full) begin
                            push_next  = 1'b1;
                            entry_next = '{valid: 1'b1, pc: pc, inst: bus.imem_rdata};
                            pc_next    = pc + 32'd4;
                            state_next = REQ;
                        end else begin
                            hold_load  = 1'b1;
                            state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (hold_valid && !bus.iq_full) begin
                        push_next  = 1'b1;
                        entry_next = hold_q;
                        pc_next    = pc + 32'd4;
                        hold_clear = 1'b1;
                        state_next = REQ;
                    end
                end
                DRAIN: begin
                    if (bus.imem_resp) state_next = REQ;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            push_q  <= 1'b0;
            entry_q <= '0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            push_q  <= push_next;
            entry_q <= entry_next;
        end
    end

    assign bus.imem_addr  = pc;
    assign bus.imem_rmask = (state == REQ && !rst) ? IMEM_RMASK_ALL : 4'h0;
    assign bus.iq_push    = push_q;
    assign bus.iq_entry   = entry_q;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push_q && perf_fetched != 32'hFFFFFFFF)        perf_fetched <= perf_fetched + 32'd1;
            if (state == HOLD && perf_stall != 32'hFFFFFFFF)   perf_stall   <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, queue backpressure, redirects, pc wrap, reset and perf counters.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h1eceb000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    fetch_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered with the DUT in REQ; leaves it in REQ at addr+4 with the push visible.
    task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] inst);
        chk({tag, "_rmask"}, 65'(bus.imem_rmask), 65'(4'hF));
        chk({tag, "_addr"},  65'(bus.imem_addr),  65'(addr));
        tick();
        chk({tag, "_wait_rmask"}, 65'(bus.imem_rmask), 65'(4'h0));
        chk({tag, "_wait_push"},  65'(bus.iq_push),    65'(1'b0));
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = inst;
        tick();
        bus.imem_resp  = 1'b0;
        chk({tag, "_push"},  65'(bus.iq_push), 65'(1'b1));
        chk({tag, "_entry"}, bus.iq_entry,     {1'b1, addr, inst});
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_rdata     = '0;
        bus.imem_resp      = 1'b0;
        bus.iq_full        = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_rmask", 65'(bus.imem_rmask), 65'(4'h0));
        chk("rst_push",  65'(bus.iq_push),    65'(1'b0));
        chk("rst_entry", bus.iq_entry,        65'(0));
        chk("rst_addr",  65'(bus.imem_addr),  65'(RST_PC));
        rst = 1'b0;
        chk("idle_rmask", 65'(bus.imem_rmask), 65'(4'h0));
        tick();

        // Streaming with k=1, one push every two cycles
        do_fetch("s0", 32'h1eceb000, 32'hA0A0_0001);
        do_fetch("s1", 32'h1eceb004, 32'hA0A0_0002);

        // Queue full on response: four HOLD cycles, then one push of the held entry
        chk("h_req_addr", 65'(bus.imem_addr), 65'(32'h1eceb008));
        tick();
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 32'h0000_0013;
        bus.iq_full    = 1'b1;
        tick();
        bus.imem_resp  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_push",  65'(bus.iq_push),    65'(1'b0));
            chk("hold_rmask", 65'(bus.imem_rmask), 65'(4'h0));
            tick();
        end
        chk("hold4_push", 65'(bus.iq_push), 65'(1'b0));
        bus.iq_full = 1'b0;
        tick();
        chk("hold_out_push",  65'(bus.iq_push),    65'(1'b1));
        chk("hold_out_entry", bus.iq_entry,        {1'b1, 32'h1eceb008, 32'h0000_0013});
        chk("hold_out_rmask", 65'(bus.imem_rmask), 65'(4'hF));
        chk("hold_out_addr",  65'(bus.imem_addr),  65'(32'h1eceb00c));

        // Redirect in REQ to 0x101: aligned to 0x100, outstanding response drained
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0101;
        tick();
        bus.redirect_valid = 1'b0;
        chk("rq_drain_rmask", 65'(bus.imem_rmask), 65'(4'h0));
        chk("rq_drain_addr",  65'(bus.imem_addr),  65'(32'h100));
        tick();
        chk("rq_drain2_rmask", 65'(bus.imem_rmask), 65'(4'h0));
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_resp  = 1'b0;
        chk("rq_drain_push", 65'(bus.iq_push),    65'(1'b0));
        chk("rq_req_rmask",  65'(bus.imem_rmask), 65'(4'hF));
        chk("rq_req_addr",   65'(bus.imem_addr),  65'(32'h100));

        // Redirect in WAIT (pc 0x100, target 0x2002): the stale response is discarded
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_2002;
        tick();
        bus.redirect_valid = 1'b0;
        chk("wr_drain_rmask", 65'(bus.imem_rmask), 65'(4'h0));
        chk("wr_drain_addr",  65'(bus.imem_addr),  65'(32'h2000));
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 32'hBAD0_0BAD;
        tick();
        bus.imem_resp  = 1'b0;
        chk("wr_push",  65'(bus.iq_push),  65'(1'b0));
        chk("wr_entry", bus.iq_entry,      65'(0));
        do_fetch("r0", 32'h0000_2000, 32'h1111_2222);

        // Redirect coincident with a response: no push, straight to REQ at the target
        tick();
        bus.imem_resp      = 1'b1;
        bus.imem_rdata     = 32'h3333_4444;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.imem_resp      = 1'b0;
        bus.redirect_valid = 1'b0;
        chk("rr_push",  65'(bus.iq_push), 65'(1'b0));
        chk("rr_entry", bus.iq_entry,     65'(0));

        // pc wraps from 0xFFFFFFFC to 0
        do_fetch("wrap", 32'hFFFF_FFFC, 32'h5555_0000);
        for (int i = 0; i < 5; i++)
            do_fetch("post_wrap", 32'(i * 4), 32'h6600_0000 + 32'(i));

        // Reset asserted in WAIT
        tick();
`ifdef FETCH_PERF_EN
        chk("perf_fetched", 65'(perf_fetched), 65'(32'd10));
        chk("perf_stall",   65'(perf_stall),   65'(32'd4));
`endif
        rst = 1'b1;
        tick();
        chk("mid_rst_rmask", 65'(bus.imem_rmask), 65'(4'h0));
        chk("mid_rst_push",  65'(bus.iq_push),    65'(1'b0));
        chk("mid_rst_entry", bus.iq_entry,        65'(0));
        chk("mid_rst_addr",  65'(bus.imem_addr),  65'(RST_PC));
`ifdef FETCH_PERF_EN
        chk("perf_fetched_rst", 65'(perf_fetched), 65'(0));
        chk("perf_stall_rst",   65'(perf_stall),   65'(0));
`endif
        rst = 1'b0;
        tick();

        // Redirect in HOLD drops the held entry
        chk("hr_req_addr", 65'(bus.imem_addr), 65'(RST_PC));
        tick();
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 32'h7777_7777;
        bus.iq_full    = 1'b1;
        tick();
        bus.imem_resp      = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_4000;
        tick();
        bus.redirect_valid = 1'b0;
        bus.iq_full        = 1'b0;
        chk("hr_push",  65'(bus.iq_push), 65'(1'b0));
        chk("hr_entry", bus.iq_entry,     65'(0));
        do_fetch("hr_next", 32'h0000_4000, 32'h8888_0001);

        // Repeated redirect while draining without a response keeps updating pc
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_5000;
        tick();
        bus.redirect_pc    = 32'h0000_6003;
        tick();
        bus.redirect_valid = 1'b0;
        chk("dd_rmask", 65'(bus.imem_rmask), 65'(4'h0));
        chk("dd_addr",  65'(bus.imem_addr),  65'(32'h6000));
        bus.imem_resp = 1'b1;
        tick();
        bus.imem_resp = 1'b0;
        chk("dd_push", 65'(bus.iq_push), 65'(1'b0));
        do_fetch("dd_next", 32'h0000_6000, 32'h9999_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
